// File: rtl/l2_bank_tcdm_adapter.sv
// TCDM slave port in front of a single-cycle SRAM bank: one request per cycle,
// in-order responses through a fall-through path plus a 2-entry skid FIFO.
module l2_bank_tcdm_adapter #(
  parameter  int unsigned NumWords  = 32768,
  parameter  int unsigned DataWidth = 32,
  localparam int unsigned AW        = $clog2(NumWords),
  localparam int unsigned BW        = DataWidth / 8,
  localparam int unsigned OFF       = $clog2(BW)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_i,
  output logic                 gnt_o,
  input  logic [AW+OFF-1:0]    add_i,
  input  logic                 wen_i,
  input  logic [DataWidth-1:0] wdata_i,
  input  logic [BW-1:0]        be_i,
  output logic                 r_valid_o,
  input  logic                 r_ready_i,
  output logic [DataWidth-1:0] r_rdata_o,
  output logic                 r_opc_o,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic [AW-1:0]        mem_addr_o,
  output logic [DataWidth-1:0] mem_wdata_o,
  output logic [BW-1:0]        mem_be_o,
  input  logic [DataWidth-1:0] mem_rdata_i
);

  localparam logic [AW:0] NumWordsW = (AW + 1)'(NumWords);

  logic [AW-1:0]        wa;
  logic                 in_range;
  logic [1:0]           count;
  logic [1:0]           occ;
  logic                 inflight;
  logic                 inflight_we;
  logic                 inflight_err;
  logic                 rd_ptr;
  logic                 wr_ptr;
  logic [DataWidth-1:0] fifo_data [2];
  logic                 fifo_opc  [2];
  logic                 head_valid;
  logic [DataWidth-1:0] rsp_data;
  logic                 pop;
  logic                 push;
  logic                 fifo_pop;

  assign wa       = add_i[OFF +: AW];
  assign in_range = {1'b0, wa} < NumWordsW;

  // count + inflight is the number of granted but not yet consumed responses
  assign occ        = count + {1'b0, inflight};
  assign head_valid = (count != 2'd0);
  assign rsp_data   = (inflight_we | inflight_err) ? '0 : mem_rdata_i;

  always_comb begin
    r_valid_o = head_valid | inflight;
    r_rdata_o = '0;
    r_opc_o   = 1'b0;
    if (head_valid) begin
      r_rdata_o = fifo_data[rd_ptr];
      r_opc_o   = fifo_opc[rd_ptr];
    end else if (inflight) begin
      r_rdata_o = rsp_data;
      r_opc_o   = inflight_err;
    end
  end

  assign pop      = r_valid_o & r_ready_i;
  assign gnt_o    = req_i & ((occ < 2'd2) | pop);
  assign push     = inflight & ~(~head_valid & pop);
  assign fifo_pop = head_valid & pop;

  assign mem_req_o   = gnt_o & in_range & rst_ni;
  assign mem_we_o    = ~wen_i;
  assign mem_addr_o  = wa;
  assign mem_wdata_o = wdata_i;
  assign mem_be_o    = be_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      inflight     <= 1'b0;
      inflight_we  <= 1'b0;
      inflight_err <= 1'b0;
      count        <= 2'd0;
      rd_ptr       <= 1'b0;
      wr_ptr       <= 1'b0;
    end else begin
      inflight     <= gnt_o;
      inflight_we  <= ~wen_i;
      inflight_err <= gnt_o & ~in_range;
      if (push)     wr_ptr <= ~wr_ptr;
      if (fifo_pop) rd_ptr <= ~rd_ptr;
      case ({push, fifo_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Payload storage needs no reset: count gates every read of it.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_data[wr_ptr] <= rsp_data;
      fifo_opc[wr_ptr]  <= inflight_err;
    end
  end

endmodule

// File: tb/tb_l2_bank_tcdm_adapter.sv
// Bench for l2_bank_tcdm_adapter: directed vector table, hand sequences for
// backpressure and reset, and random traffic against a transaction-level model.
module tb_l2_bank_tcdm_adapter;

  localparam int NW = 24;
  localparam int DW = 32;

  logic        clk;
  logic        rst_n;
  logic        req_i;
  logic        gnt_o;
  logic [6:0]  add_i;
  logic        wen_i;
  logic [31:0] wdata_i;
  logic [3:0]  be_i;
  logic        r_valid_o;
  logic        r_ready_i;
  logic [31:0] r_rdata_o;
  logic        r_opc_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [4:0]  mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_rdata_i;

  l2_bank_tcdm_adapter #(.NumWords(NW), .DataWidth(DW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req_i), .gnt_o(gnt_o), .add_i(add_i),
    .wen_i(wen_i), .wdata_i(wdata_i), .be_i(be_i), .r_valid_o(r_valid_o),
    .r_ready_i(r_ready_i), .r_rdata_o(r_rdata_o), .r_opc_o(r_opc_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_rdata_i(mem_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // SRAM model: synchronous, one-cycle read latency, byte-enabled writes
  logic [31:0] sram [0:31];
  always @(posedge clk) begin
    if (mem_req_o) begin
      if (mem_we_o) begin
        for (int b = 0; b < 4; b++)
          if (mem_be_o[b]) sram[mem_addr_o][8*b +: 8] <= mem_wdata_o[8*b +: 8];
      end else begin
        mem_rdata_i <= sram[mem_addr_o];
      end
    end
  end

  // Reference: the list of granted-but-unconsumed responses plus a shadow memory
  typedef struct { logic [31:0] data; logic opc; } rsp_t;
  rsp_t        q[$];
  logic [31:0] ref_mem [0:NW-1];
  int          m_wa;
  logic        m_gnt;
  rsp_t        m_rsp;

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
    end else begin
      m_wa  = int'(add_i[6:2]);
      m_gnt = req_i && (q.size() < 2 || (q.size() > 0 && r_ready_i));
      check("mdl_gnt", 32'(gnt_o), 32'(m_gnt));
      check("mdl_rvalid", 32'(r_valid_o), 32'(q.size() > 0));
      if (q.size() > 0) begin
        check("mdl_rdata", r_rdata_o, q[0].data);
        check("mdl_opc", 32'(r_opc_o), 32'(q[0].opc));
      end
      check("mdl_mem_req", 32'(mem_req_o), 32'(m_gnt && m_wa < NW));
      if (m_gnt && m_wa < NW) begin
        check("mdl_mem_we", 32'(mem_we_o), 32'(!wen_i));
        check("mdl_mem_addr", 32'(mem_addr_o), 32'(m_wa));
        check("mdl_mem_wdata", mem_wdata_o, wdata_i);
        check("mdl_mem_be", 32'(mem_be_o), 32'(be_i));
      end
      if (q.size() > 0 && r_ready_i) void'(q.pop_front());
      if (m_gnt) begin
        m_rsp.data = '0;
        m_rsp.opc  = 1'b0;
        if (m_wa >= NW) m_rsp.opc = 1'b1;
        else if (wen_i) m_rsp.data = ref_mem[m_wa];
        else
          for (int b = 0; b < 4; b++)
            if (be_i[b]) ref_mem[m_wa][8*b +: 8] = wdata_i[8*b +: 8];
        q.push_back(m_rsp);
      end
      check("mdl_outstanding_le2", 32'(q.size() <= 2), 32'd1);
    end
  end

  typedef struct {
    logic req; logic wen; logic [6:0] add; logic [31:0] wdata; logic [3:0] be; logic ready;
    logic e_gnt; logic e_mreq; logic e_rvalid; logic [31:0] e_rdata; logic e_opc;
  } vec_t;
  vec_t vecs[$];

  function automatic vec_t mk(logic req, logic wen, logic [6:0] add, logic [31:0] wdata,
                              logic [3:0] be, logic ready, logic e_gnt, logic e_mreq,
                              logic e_rvalid, logic [31:0] e_rdata, logic e_opc);
    vec_t v;
    v.req = req; v.wen = wen; v.add = add; v.wdata = wdata; v.be = be; v.ready = ready;
    v.e_gnt = e_gnt; v.e_mreq = e_mreq; v.e_rvalid = e_rvalid; v.e_rdata = e_rdata; v.e_opc = e_opc;
    return v;
  endfunction

  task automatic apply(input logic req, input logic wen, input logic [6:0] add,
                       input logic [31:0] wdata, input logic [3:0] be, input logic ready);
    req_i = req; wen_i = wen; add_i = add; wdata_i = wdata; be_i = be; r_ready_i = ready;
    @(negedge clk);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) sram[i] = 32'h1000_0000 + 32'(i);
    for (int i = 0; i < NW; i++) ref_mem[i] = 32'h1000_0000 + 32'(i);
    mem_rdata_i = '0;
    rst_n = 1'b0;
    req_i = 0; wen_i = 1; add_i = '0; wdata_i = '0; be_i = '0; r_ready_i = 0;
    #1;
    check("rst_rvalid", 32'(r_valid_o), 32'd0);
    check("rst_opc", 32'(r_opc_o), 32'd0);
    check("rst_rdata", r_rdata_o, 32'd0);
    check("rst_mem_req", 32'(mem_req_o), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    //          req wen add    wdata         be    rdy | gnt mreq rv rdata          opc
    vecs.push_back(mk(1, 0, 7'h10, 32'hDEADBEEF, 4'hF, 1, 1, 1, 0, 32'h0,         0));
    vecs.push_back(mk(1, 1, 7'h10, 32'h0,        4'hF, 1, 1, 1, 1, 32'h0,         0));
    vecs.push_back(mk(0, 1, 7'h00, 32'h0,        4'h0, 1, 0, 0, 1, 32'hDEADBEEF,  0));
    vecs.push_back(mk(1, 0, 7'h14, 32'h11223344, 4'hF, 1, 1, 1, 0, 32'h0,         0));
    vecs.push_back(mk(1, 0, 7'h14, 32'hAABBCCDD, 4'h3, 1, 1, 1, 1, 32'h0,         0));
    vecs.push_back(mk(1, 1, 7'h14, 32'h0,        4'hF, 1, 1, 1, 1, 32'h0,         0));
    vecs.push_back(mk(0, 1, 7'h00, 32'h0,        4'h0, 1, 0, 0, 1, 32'h1122CCDD,  0));
    vecs.push_back(mk(1, 1, 7'd120, 32'h0,       4'hF, 1, 1, 0, 0, 32'h0,         0));
    vecs.push_back(mk(0, 1, 7'h00, 32'h0,        4'h0, 1, 0, 0, 1, 32'h0,         1));
    vecs.push_back(mk(1, 1, 7'd96, 32'h0,        4'hF, 1, 1, 0, 0, 32'h0,         0));
    vecs.push_back(mk(1, 1, 7'd92, 32'h0,        4'hF, 1, 1, 1, 1, 32'h0,         1));
    vecs.push_back(mk(0, 1, 7'h00, 32'h0,        4'h0, 1, 0, 0, 1, 32'h10000017,  0));
    vecs.push_back(mk(1, 1, 7'h13, 32'h0,        4'hF, 1, 1, 1, 0, 32'h0,         0));
    vecs.push_back(mk(0, 1, 7'h00, 32'h0,        4'h0, 1, 0, 0, 1, 32'hDEADBEEF,  0));
    vecs.push_back(mk(0, 1, 7'h00, 32'h0,        4'h0, 1, 0, 0, 0, 32'h0,         0));

    foreach (vecs[i]) begin
      apply(vecs[i].req, vecs[i].wen, vecs[i].add, vecs[i].wdata, vecs[i].be, vecs[i].ready);
      check($sformatf("vec%0d_gnt", i), 32'(gnt_o), 32'(vecs[i].e_gnt));
      check($sformatf("vec%0d_mem_req", i), 32'(mem_req_o), 32'(vecs[i].e_mreq));
      check($sformatf("vec%0d_rvalid", i), 32'(r_valid_o), 32'(vecs[i].e_rvalid));
      if (vecs[i].e_rvalid) begin
        check($sformatf("vec%0d_rdata", i), r_rdata_o, vecs[i].e_rdata);
        check($sformatf("vec%0d_opc", i), 32'(r_opc_o), 32'(vecs[i].e_opc));
      end
      next_cycle();
    end

    // Backpressure: four reads with the consumer stalled, then released
    apply(1, 1, 7'h00, 0, 4'hF, 0); check("bp_a_gnt", 32'(gnt_o), 1); next_cycle();
    apply(1, 1, 7'h04, 0, 4'hF, 0); check("bp_b_gnt", 32'(gnt_o), 1);
    check("bp_b_rdata", r_rdata_o, 32'h1000_0000); next_cycle();
    apply(1, 1, 7'h08, 0, 4'hF, 0); check("bp_c_gnt", 32'(gnt_o), 0); next_cycle();
    apply(1, 1, 7'h08, 0, 4'hF, 0); check("bp_d_gnt", 32'(gnt_o), 0);
    check("bp_d_rvalid", 32'(r_valid_o), 1); next_cycle();
    apply(1, 1, 7'h08, 0, 4'hF, 1); check("bp_e_gnt", 32'(gnt_o), 1);
    check("bp_e_rdata", r_rdata_o, 32'h1000_0000); next_cycle();
    apply(1, 1, 7'h0C, 0, 4'hF, 1); check("bp_f_gnt", 32'(gnt_o), 1);
    check("bp_f_rdata", r_rdata_o, 32'h1000_0001); next_cycle();
    apply(0, 1, 7'h00, 0, 4'h0, 1); check("bp_g_rdata", r_rdata_o, 32'h1000_0002); next_cycle();
    apply(0, 1, 7'h00, 0, 4'h0, 1); check("bp_h_rdata", r_rdata_o, 32'h1000_0003); next_cycle();
    apply(0, 1, 7'h00, 0, 4'h0, 1); check("bp_i_rvalid", 32'(r_valid_o), 0); next_cycle();

    // Reset with two buffered responses
    apply(1, 1, 7'h18, 0, 4'hF, 0); check("rs_a_gnt", 32'(gnt_o), 1); next_cycle();
    apply(1, 1, 7'h1C, 0, 4'hF, 0); check("rs_b_gnt", 32'(gnt_o), 1); next_cycle();
    apply(0, 1, 7'h00, 0, 4'h0, 0); next_cycle();
    apply(0, 1, 7'h00, 0, 4'h0, 0); check("rs_full_rvalid", 32'(r_valid_o), 1);
    check("rs_full_rdata", r_rdata_o, 32'h1000_0006);
    #2;
    req_i = 1'b1; add_i = 7'h20;
    rst_n = 1'b0;
    #1;
    check("rs_mid_rvalid", 32'(r_valid_o), 0);
    check("rs_mid_opc", 32'(r_opc_o), 0);
    check("rs_mid_rdata", r_rdata_o, 32'h0);
    check("rs_mid_mem_req", 32'(mem_req_o), 0);
    req_i = 1'b0;
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
    apply(1, 1, 7'h20, 0, 4'hF, 1); check("rs_post_gnt", 32'(gnt_o), 1);
    check("rs_post_rvalid0", 32'(r_valid_o), 0); next_cycle();
    apply(0, 1, 7'h00, 0, 4'h0, 1); check("rs_post_rvalid1", 32'(r_valid_o), 1);
    check("rs_post_rdata", r_rdata_o, 32'h1000_0008); next_cycle();

    // Random traffic, including out-of-range addresses and stalls
    for (int i = 0; i < 600; i++) begin
      apply(($urandom % 4) != 0, ($urandom % 3) != 0,
            7'({5'($urandom_range(0, 27)), 2'($urandom)}),
            $urandom, 4'($urandom), ($urandom % 2) != 0);
      next_cycle();
    end
    for (int i = 0; i < 4; i++) begin
      apply(0, 1, 7'h00, 0, 4'h0, 1);
      next_cycle();
    end
    apply(0, 1, 7'h00, 0, 4'h0, 1);
    check("drain_rvalid", 32'(r_valid_o), 0);
    check("drain_model_empty", 32'(q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
